// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-ported, multi-cycle main memory between the instruction
// cache and data cache miss handlers. Only one operation runs at a time. It is
// either a WORDS-word block fill or a single-word data write-through. Fill
// reads are issued back-to-back. The returned words are then steered into
// the owning cache, and a one-cycle done strobe ends the operation.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   i_req, i_addr         instruction-side fill request (level) and address
//   d_req, d_we           data-side request (level); d_we selects write-through
//   d_addr, d_wdata       data-side byte address and write-through data
//   mem_en, mem_wr        memory access issue / access is a write
//   mem_addr, mem_wdata   memory byte address and write data
//   mem_rdata, mem_valid  memory read data and its valid strobe
//   fill_data, fill_word  word being returned and its index within the block
//   i_fill_we, d_fill_we  cache data-array write enables
//   i_done, d_done        one-cycle completion strobes
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [15:0]              i_addr,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [15:0]              d_addr,
  input  logic [15:0]              d_wdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_valid,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_done,
  output logic                     d_done
);

  localparam int IDXW = $clog2(WORDS);
  // The issue counter must be able to hold WORDS itself, since it saturates there.
  localparam int CNTW = IDXW + 1;
  localparam logic [15:0]      FILL_MASK  = ~16'(2 * WORDS - 1);
  localparam logic [15:0]      WRITE_MASK = 16'hFFFE;
  localparam logic [CNTW-1:0]  ISSUE_MAX  = CNTW'(WORDS);
  localparam logic [IDXW-1:0]  LAST_WORD  = IDXW'(WORDS - 1);

  // The FSM counts returned beats rather than cycles, so MEM_LAT only
  // documents the memory. A zero-latency memory is not a configuration
  // this block is meant for, so nothing is generated for it.
  if (MEM_LAT < 1) begin : g_zeroLatencyUnsupported
  end

  typedef enum logic [1:0] {
    IDLE,
    I_FILL,
    D_FILL,
    D_WRITE
  } state_t;

  state_t            r_state;
  logic [15:0]       r_base;
  logic [15:0]       r_wdata;
  logic [CNTW-1:0]   r_issueCnt;
  logic [IDXW-1:0]   r_retCnt;
  logic              r_lastGrant;

  state_t            w_nextState;
  logic [15:0]       w_nextBase;
  logic [15:0]       w_nextWdata;
  logic [CNTW-1:0]   w_nextIssue;
  logic [IDXW-1:0]   w_nextRet;
  logic              w_nextLast;
  logic              w_grantI;
  logic              w_grantD;
  logic              w_issuing;
  logic              w_lastBeat;

  // Round-robin: a lone requester always wins. On a tie, the side that was
  // not served last wins. r_lastGrant = 1 means D was served last.
  assign w_grantI   = i_req & (~d_req | r_lastGrant);
  assign w_grantD   = d_req & (~i_req | ~r_lastGrant);
  assign w_issuing  = (r_issueCnt < ISSUE_MAX);
  assign w_lastBeat = mem_valid & (r_retCnt == LAST_WORD);

  // State register. Reset aborts any burst. The late returns of the aborted
  // burst then arrive while in IDLE, where they are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_wdata     <= '0;
      r_issueCnt  <= '0;
      r_retCnt    <= '0;
      r_lastGrant <= 1'b1;
    end else begin
      r_state     <= w_nextState;
      r_base      <= w_nextBase;
      r_wdata     <= w_nextWdata;
      r_issueCnt  <= w_nextIssue;
      r_retCnt    <= w_nextRet;
      r_lastGrant <= w_nextLast;
    end
  end

  // Next-state and output decode.
  // Issue side: mem_en/mem_addr come only from registered state.
  // Return side: fill_data, the write enables and done follow mem_valid
  // combinationally. This lets each beat be written into the cache in the
  // cycle it arrives.
  always_comb begin
    w_nextState = r_state;
    w_nextBase  = r_base;
    w_nextWdata = r_wdata;
    w_nextIssue = r_issueCnt;
    w_nextRet   = r_retCnt;
    w_nextLast  = r_lastGrant;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;

    case (r_state)
      IDLE: begin
        w_nextIssue = '0;
        w_nextRet   = '0;
        if (w_grantI) begin
          w_nextState = I_FILL;
          w_nextBase  = i_addr & FILL_MASK;
          w_nextLast  = 1'b0;
        end else if (w_grantD) begin
          w_nextLast  = 1'b1;
          w_nextWdata = d_wdata;
          if (d_we) begin
            w_nextState = D_WRITE;
            w_nextBase  = d_addr & WRITE_MASK;
          end else begin
            w_nextState = D_FILL;
            w_nextBase  = d_addr & FILL_MASK;
          end
        end
      end

      I_FILL, D_FILL: begin
        fill_word = r_retCnt;
        if (w_issuing) begin
          mem_en      = 1'b1;
          mem_addr    = r_base + (16'(r_issueCnt) << 1);
          w_nextIssue = r_issueCnt + 1'b1;
        end
        if (mem_valid) begin
          fill_data = mem_rdata;
          if (r_state == I_FILL) begin
            i_fill_we = 1'b1;
            i_done    = w_lastBeat;
          end else begin
            d_fill_we = 1'b1;
            d_done    = w_lastBeat;
          end
          w_nextRet = r_retCnt + 1'b1;
        end
        if (w_lastBeat) begin
          w_nextState = IDLE;
          w_nextIssue = '0;
          w_nextRet   = '0;
        end
      end

      D_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_base;
        mem_wdata   = r_wdata;
        d_done      = 1'b1;
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural memory returns each read
// after MEM_LAT cycles. The return slots can be gapped, either randomly or
// from a fixed list. Expected traffic comes from the arbitration and
// addressing rules:
//   - round-robin winner
//   - aligned fill base and sequential word addresses
//   - k-th returned beat lands in word k with the memory content of base+2k
//   - done on the last beat
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;
  localparam int BUDGET  = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_done, d_done;

  mem_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int txnStart = 0;
  int gapPct = 0;
  bit forceValid = 1'b0;
  bit useAllow = 1'b0;
  bit drvValid = 1'b0;
  bit lastD = 1'b1;
  bit iPend = 1'b0;
  bit dPend = 1'b0;
  int allowList[$];

  typedef struct {
    int          ready;
    logic [15:0] data;
  } ret_t;
  ret_t rq[$];

  // Memory contents are a fixed function of the byte address.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] fillBase(input logic [15:0] a);
    return a & ~16'(2 * WORDS - 1);
  endfunction

  // Round-robin reference: D wins alone, or on a tie when I was served last.
  function automatic bit pickD(input bit ip, input bit dp);
    return dp && (!ip || !lastD);
  endfunction

  // Start of a cycle: just after the rising edge, present the next memory
  // return, if any is due and the gap pattern allows it.
  task automatic cycleBegin();
    ret_t head;
    bit   ok;
    @(posedge clk);
    #1;
    cyc++;
    ok = 1'b1;
    if (useAllow) begin
      ok = 1'b0;
      foreach (allowList[k]) if (allowList[k] == cyc - txnStart) ok = 1'b1;
    end else if (gapPct > 0) begin
      ok = ($urandom_range(0, 99) >= gapPct);
    end
    if (rq.size() > 0 && rq[0].ready <= cyc && ok) begin
      head      = rq.pop_front();
      mem_valid = 1'b1;
      mem_rdata = head.data;
    end else begin
      mem_valid = forceValid;
      mem_rdata = 16'($urandom);
    end
    drvValid = mem_valid;
  endtask

  // Middle of a cycle: the memory accepts a read issued this cycle.
  task automatic cycleEnd();
    ret_t item;
    @(negedge clk);
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      item.ready = cyc + MEM_LAT;
      item.data  = memWord(mem_addr);
      rq.push_back(item);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    mem_valid = 1'b0; forceValid = 1'b0; useAllow = 1'b0; gapPct = 0;
    iPend = 1'b0; dPend = 1'b0;
    rq.delete();
    lastD = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Runs one block fill. It starts in the current IDLE cycle (cycle 0) and
  // ends after the IDLE cycle that follows done. The owner's address is
  // scrambled once the grant has been taken.
  task automatic run_fill(input bit side, input logic [15:0] base, output int doneAt);
    int   beats;
    bit   gotDone;
    bit   expEn, expDone;
    logic ownWe, ownDone, othWe, othDone;
    beats = 0; gotDone = 1'b0; doneAt = -1;
    txnStart = cyc;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_mem_en: got %0b expected 0", mem_en);
    end
    for (int c = 1; c <= BUDGET && !gotDone; c++) begin
      cycleBegin();
      if (c == 1) begin
        if (side) d_addr = 16'($urandom); else i_addr = 16'($urandom);
      end
      cycleEnd();
      expEn = (c <= WORDS);
      checks++;
      if (mem_en !== expEn || (expEn && mem_wr !== 1'b0)) begin
        errors++; $display("[TB] FAIL fill_issue c%0d: en/wr %0b%0b expected %0b0", c, mem_en, mem_wr, expEn);
      end
      if (expEn) begin
        checks++;
        if (mem_addr !== base + 16'(2 * (c - 1))) begin
          errors++; $display("[TB] FAIL fill_addr c%0d: got %0h expected %0h", c, mem_addr, base + 16'(2 * (c - 1)));
        end
      end
      ownWe   = side ? d_fill_we : i_fill_we;
      ownDone = side ? d_done    : i_done;
      othWe   = side ? i_fill_we : d_fill_we;
      othDone = side ? i_done    : d_done;
      expDone = drvValid && (beats == WORDS - 1);
      checks++;
      if (ownWe !== drvValid || ownDone !== expDone) begin
        errors++; $display("[TB] FAIL owner_strobes c%0d: we/done %0b%0b expected %0b%0b", c, ownWe, ownDone, drvValid, expDone);
      end
      checks++;
      if (othWe !== 1'b0 || othDone !== 1'b0) begin
        errors++; $display("[TB] FAIL other_strobes c%0d: we/done %0b%0b expected 00", c, othWe, othDone);
      end
      if (drvValid) begin
        checks++;
        if (fill_word !== 3'(beats) || fill_data !== memWord(base + 16'(2 * beats))) begin
          errors++; $display("[TB] FAIL fill_beat %0d: word/data %0d/%0h expected %0d/%0h",
                             beats, fill_word, fill_data, beats, memWord(base + 16'(2 * beats)));
        end
        beats++;
      end
      if (expDone || ownDone === 1'b1) begin
        gotDone = 1'b1;
        doneAt  = c;
        if (side) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    if (!gotDone) begin
      checks++; errors++;
      $display("[TB] FAIL fill_timeout: got %0d beats expected %0d", beats, WORDS);
      if (side) d_req = 1'b0; else i_req = 1'b0;
    end
    lastD = side;
    cycleBegin();
    cycleEnd();
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("[TB] FAIL post_fill_idle: mem_en %0b expected 0", mem_en);
    end
  endtask

  // Runs one write-through. d_wdata is changed after the grant to show that
  // the write data was captured at grant.
  task automatic run_write(input logic [15:0] base, input logic [15:0] wdata);
    checks++;
    if (mem_en !== 1'b0 || d_done !== 1'b0) begin
      errors++; $display("[TB] FAIL write_idle: en/done %0b%0b expected 00", mem_en, d_done);
    end
    cycleBegin();
    d_wdata = ~wdata;
    cycleEnd();
    checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1) begin
      errors++; $display("[TB] FAIL write_issue: en/wr %0b%0b expected 11", mem_en, mem_wr);
    end
    checks++;
    if (mem_addr !== base || mem_wdata !== wdata) begin
      errors++; $display("[TB] FAIL write_bus: addr/data %0h/%0h expected %0h/%0h", mem_addr, mem_wdata, base, wdata);
    end
    checks++;
    if ({d_done, i_done, i_fill_we, d_fill_we} !== 4'b1000) begin
      errors++; $display("[TB] FAIL write_strobes: %b expected 1000", {d_done, i_done, i_fill_we, d_fill_we});
    end
    d_req = 1'b0;
    lastD = 1'b1;
    cycleBegin();
    cycleEnd();
    checks++;
    if ({mem_en, i_fill_we, d_fill_we, i_done, d_done} !== 5'b0) begin
      errors++; $display("[TB] FAIL write_after: %b expected 00000", {mem_en, i_fill_we, d_fill_we, i_done, d_done});
    end
  endtask

  // Serves whichever pending request the round-robin reference picks.
  task automatic serveOne();
    int doneAt;
    i_req = iPend;
    d_req = dPend;
    if (pickD(iPend, dPend)) begin
      dPend = 1'b0;
      if (d_we) run_write(d_addr & 16'hFFFE, d_wdata);
      else      run_fill(1'b1, fillBase(d_addr), doneAt);
    end else begin
      iPend = 1'b0;
      run_fill(1'b0, fillBase(i_addr), doneAt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 16'h1234; d_addr = 16'h5678; d_wdata = 16'h9ABC;
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wr} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_en_wr: %b expected 00", {mem_en, mem_wr});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_bus: addr/data %0h/%0h expected 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (fill_data !== 16'h0 || fill_word !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_fill: data/word %0h/%0d expected 0/0", fill_data, fill_word);
    end
    checks++;
    if ({i_fill_we, d_fill_we, i_done, d_done} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: %b expected 0000", {i_fill_we, d_fill_we, i_done, d_done});
    end
    doReset();
  endtask

  task automatic test_single_fill();
    int doneAt;
    i_addr = 16'h1236;
    i_req  = 1'b1;
    run_fill(1'b0, 16'h1230, doneAt);
    checks++;
    if (doneAt != 12) begin
      errors++; $display("[TB] FAIL single_done_cycle: got %0d expected 12", doneAt);
    end
  endtask

  task automatic test_write();
    d_addr = 16'h0042; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
    forceValid = 1'b1;
    run_write(16'h0042, 16'hBEEF);
    forceValid = 1'b0;
    d_we = 1'b0;
  endtask

  task automatic test_gapped();
    int doneAt;
    allowList = '{5, 7, 8, 11, 12, 13, 15, 16};
    useAllow = 1'b1;
    d_addr = 16'h4A5C; d_we = 1'b0; d_req = 1'b1;
    run_fill(1'b1, 16'h4A50, doneAt);
    useAllow = 1'b0;
    checks++;
    if (doneAt != 16) begin
      errors++; $display("[TB] FAIL gapped_done_cycle: got %0d expected 16", doneAt);
    end
  endtask

  task automatic test_arbitration();
    doReset();
    i_addr = 16'h2004; d_addr = 16'h3018; d_we = 1'b0;
    iPend = 1'b1; dPend = 1'b1;
    serveOne();
    serveOne();
    for (int n = 0; n < 3; n++) begin
      if (!iPend) begin iPend = 1'b1; i_addr = 16'($urandom); end
      if (!dPend) begin dPend = 1'b1; d_addr = 16'($urandom); end
      serveOne();
    end
    serveOne();
  endtask

  task automatic test_reset_midfill();
    int          beats;
    int          doneAt;
    logic [15:0] base2;
    doReset();
    i_addr = 16'h7778; i_req = 1'b1;
    txnStart = cyc;
    beats = 0;
    for (int c = 1; c <= BUDGET && beats < 3; c++) begin
      cycleBegin();
      cycleEnd();
      checks++;
      if (i_fill_we !== drvValid) begin
        errors++; $display("[TB] FAIL pre_abort_we c%0d: got %0b expected %0b", c, i_fill_we, drvValid);
      end
      if (drvValid) beats++;
    end
    #2 rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we, d_fill_we, i_done, d_done} !== '0) begin
      errors++; $display("[TB] FAIL abort_outputs: en %0b addr %0h data %0h we %0b expected all 0", mem_en, mem_addr, fill_data, i_fill_we);
    end
    lastD = 1'b1;
    cycleBegin();
    cycleEnd();
    #2 rst_n = 1'b1;
    forceValid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cycleBegin();
      cycleEnd();
      checks++;
      if ({mem_en, i_fill_we, d_fill_we, i_done, d_done} !== 5'b0) begin
        errors++; $display("[TB] FAIL stray_beat %0d: %b expected 00000", s, {mem_en, i_fill_we, d_fill_we, i_done, d_done});
      end
    end
    forceValid = 1'b0;
    rq.delete();
    base2 = 16'h0A10;
    i_addr = 16'h0A1E; i_req = 1'b1;
    run_fill(1'b0, base2, doneAt);
    checks++;
    if (doneAt != 12) begin
      errors++; $display("[TB] FAIL refill_done_cycle: got %0d expected 12", doneAt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      gapPct = $urandom_range(0, 40);
      if (!iPend && ($urandom_range(0, 1) == 1)) begin
        iPend = 1'b1; i_addr = 16'($urandom);
      end
      if (!dPend && (($urandom_range(0, 1) == 1) || !iPend)) begin
        dPend = 1'b1; d_addr = 16'($urandom); d_wdata = 16'($urandom);
        d_we = ($urandom_range(0, 2) == 0);
      end
      serveOne();
    end
    gapPct = 0;
    i_req = 1'b0; d_req = 1'b0; iPend = 1'b0; dPend = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_write();
    test_gapped();
    test_arbitration();
    test_reset_midfill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller that shares the single-ported, multi-cycle unified main memory between the instruction-side and data-side cache miss handlers of the pipelined CPU. It arbitrates pending requests and runs one 8-word block fill or one single-word write-through at a time. It issues pipelined memory reads, steers returned words into the requesting cache, and pulses a completion strobe. It sits below the IF and MEM stages; the caches turn `req & ~done` into pipeline stall.

## Interface
- `WORDS`, 8: words per cache block (power of two); block = 2*WORDS bytes.
- `MEM_LAT`, 4: memory read latency in cycles, issue to `mem_valid`. Informational only; the FSM counts returns, not cycles.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction-side block-fill request; level, held until `i_done`.
- `i_addr`  in  16  instruction miss byte address.
- `d_req`  in  1  data-side request; level, held until `d_done`.
- `d_we`  in  1  with `d_req`: 1 = single-word write-through, 0 = block fill.
- `d_addr`  in  16  data byte address.
- `d_wdata`  in  16  write-through data.
- `mem_en`  out  1  memory access issue this cycle.
- `mem_wr`  out  1  issued access is a write.
- `mem_addr`  out  16  memory byte address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data.
- `mem_valid`  in  1  `mem_rdata` valid this cycle.
- `fill_data`  out  16  word to write into a cache (= `mem_rdata`).
- `fill_word`  out  3  word index within the block, log2(WORDS) bits.
- `i_fill_we`, `d_fill_we`  out  1 each  cache data-array write enables.
- `i_done`, `d_done`  out  1 each  one-cycle completion pulses.

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. Registers: `state`, `base[15:0]`, `issue_cnt`, `ret_cnt`, `last_grant` (0 = I, 1 = D).
- IDLE arbitration, evaluated each cycle:
  - Only one requester pending: that requester is granted.
  - Both pending: the side opposite `last_grant` is granted (round-robin).
  - A D grant goes to D_WRITE if `d_we`, else to D_FILL. An I grant goes to I_FILL.
  - On grant, latch `base` and set `last_grant`.
- Fill `base` = addr with bits [log2(2*WORDS)-1:0] cleared (addr & 16'hFFF0 for WORDS=8). Write `base` = `d_addr` unaligned, bit 0 cleared.
- Fill issue:
  - `mem_en`=1, `mem_wr`=0, `mem_addr` = `base + 2*issue_cnt` on every fill cycle while `issue_cnt < WORDS`.
  - `issue_cnt` increments per issue and saturates at WORDS. Words are issued in order 0..WORDS-1, one per cycle.
- Fill return:
  - Each `mem_valid` in a fill state asserts the owning side's `*_fill_we` with `fill_word = ret_cnt`, `fill_data = mem_rdata`, then increments `ret_cnt`.
  - When `ret_cnt == WORDS-1` and `mem_valid`, the owning `*_done` pulses in the same cycle. Next state is IDLE; both counters clear.
- D_WRITE lasts one cycle: `mem_en`=1, `mem_wr`=1, `mem_addr` = base, `mem_wdata` = `d_wdata` (registered at grant). `d_done` pulses in that cycle; next state is IDLE.
- Requester protocol: the requester deasserts `req` on the clock edge ending its `done` cycle. A `req` still high in the following IDLE cycle is a new request.
- `mem_valid` outside I_FILL/D_FILL, or from an aborted burst, is ignored. No `*_fill_we` or `done` is generated for it.
- `i_addr`/`d_addr` changes after grant have no effect.
- Only the owning side's `*_fill_we`/`*_done` may ever assert. The other side's strobes are 0 throughout.

## Timing
- Reset (async, any state): state IDLE, all counters 0, `last_grant`=1 (first tie goes to I). All outputs 0: `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `fill_data`, `fill_word`, both fill enables, both done strobes.
- Reset during a burst aborts it. Later in-flight `mem_valid` beats are dropped per the rule above.
- Cycle 0 (IDLE): request sampled and grant decided. Cycles 1..WORDS: issue. With MEM_LAT=4, returns arrive in cycles 5..12, with `done` in cycle 12 and IDLE in cycle 13.
- Fill occupancy is WORDS+MEM_LAT+1 cycles including the IDLE cycle. Write occupancy is 2 cycles (IDLE + D_WRITE).
- `mem_valid` may be bursty or gapped; correctness depends only on its count, never on cycle position.
- All outputs are decoded from registered state/counters, except `fill_data`, `*_fill_we` and `*_done`, which are combinational from `mem_valid`/`mem_rdata`.

## Test plan
- Reset, then `i_req` with `i_addr`=16'h1236 → `mem_addr` 16'h1230,1232,…,123E on cycles 1–8. `i_fill_we` on cycles 5–12 with `fill_word` 0–7. `i_done` on cycle 12. `d_*` strobes stay 0.
- `i_req` and `d_req` (fill) asserted together right after reset → I is served first, then D is granted in the IDLE cycle after `i_done`. With both re-asserted afterwards, service alternates I, D, I.
- `d_req`, `d_we`=1, `d_addr`=16'h0042, `d_wdata`=16'hBEEF → one cycle with `mem_en`=1, `mem_wr`=1, `mem_addr` 16'h0042, `mem_wdata` 16'hBEEF, and `d_done`. No fill enables.
- D fill with `mem_valid` gapped (returns on cycles 5,7,8,11,12,13,15,16) → 8 `d_fill_we` beats with `fill_word` 0–7 in order. `d_done` on cycle 16.
- `rst_n` pulsed low mid-fill after 3 returns, then 5 stray `mem_valid` beats → all outputs 0 immediately, stray beats produce no enables. A new `i_req` completes a normal 8-word fill.
- `mem_valid` asserted while in IDLE and during D_WRITE → no `*_fill_we` and no `*_done` beyond the write's own `d_done`.
